// File: rtl/mc14500b_pkg.sv
// Shared definitions for the mc14500b program sequencer: ICU opcodes,
// fetch FSM encoding and default address width.
package mc14500b_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned OP_W       = 4;

  // Opcode encoding, identical to the ICU instruction decoder
  localparam logic [OP_W-1:0] OP_NOPO = 4'h0;
  localparam logic [OP_W-1:0] OP_LD   = 4'h1;
  localparam logic [OP_W-1:0] OP_LDC  = 4'h2;
  localparam logic [OP_W-1:0] OP_AND  = 4'h3;
  localparam logic [OP_W-1:0] OP_ANDC = 4'h4;
  localparam logic [OP_W-1:0] OP_OR   = 4'h5;
  localparam logic [OP_W-1:0] OP_ORC  = 4'h6;
  localparam logic [OP_W-1:0] OP_XNOR = 4'h7;
  localparam logic [OP_W-1:0] OP_STO  = 4'h8;
  localparam logic [OP_W-1:0] OP_STOC = 4'h9;
  localparam logic [OP_W-1:0] OP_IEN  = 4'hA;
  localparam logic [OP_W-1:0] OP_OEN  = 4'hB;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hC;
  localparam logic [OP_W-1:0] OP_RTN  = 4'hD;
  localparam logic [OP_W-1:0] OP_SKZ  = 4'hE;
  localparam logic [OP_W-1:0] OP_NOPF = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERR   = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/mc14500b_ret_stack.sv
// Return-address LIFO. Push/pop requests against a full/empty stack are
// dropped here; deciding that they are errors is left to the sequencer.
module mc14500b_ret_stack
  import mc14500b_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = ADDR_W_DEF,
  parameter int unsigned SP_W   = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_top_c,
  output logic [SP_W-1:0]   o_sp,
  output logic              o_full_c,
  output logic              o_empty_c
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [0:(1 << IDX_W)-1];
  logic [SP_W-1:0]   r_sp;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full_c  = (r_sp == SP_W'(DEPTH));
  assign o_empty_c = (r_sp == '0);
  assign w_do_push = i_push && !o_full_c;
  assign w_do_pop  = i_pop && !w_do_push && !o_empty_c;

  // sp counts occupied entries, so the top lives at sp-1
  assign o_top_c = r_mem[IDX_W'(r_sp - SP_W'(1))];
  assign o_sp    = r_sp;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[IDX_W'(r_sp)] <= i_din;
    end
  end

endmodule

// File: rtl/mc14500b_fetch_seq.sv
// Program sequencer for the mc14500b ICU: PC, return stack and ROM fetch.
// MC14500B_HALT_ON_NOPF_EN: step with flgf halts after advancing the PC.
module mc14500b_fetch_seq
  import mc14500b_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned SP_W        = 3
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   step,
  input  logic                   jmp,
  input  logic                   rtn,
  input  logic                   flgf,
  output logic [ADDR_W-1:0]      prog_addr,
  input  logic [OP_W+ADDR_W-1:0] prog_data,
  output logic [OP_W-1:0]        I,
  output logic [ADDR_W-1:0]      io_addr,
  output logic                   instr_valid,
  output logic                   running,
  output logic                   stack_err,
  output logic [SP_W-1:0]        sp
);

  localparam int unsigned IR_W = OP_W + ADDR_W;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [IR_W-1:0]   r_ir;
  logic [IR_W-1:0]   w_ir_nxt;
  logic              r_instr_valid;
  logic              w_instr_valid_nxt;
  logic              r_running;
  logic              w_running_nxt;
  logic              r_stack_err;
  logic              w_stack_err_nxt;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_stack_top;
  logic              w_stack_full;
  logic              w_stack_empty;
  logic              w_push;
  logic              w_pop;

`ifndef MC14500B_HALT_ON_NOPF_EN
  logic w_unused_flgf;
  assign w_unused_flgf = flgf;
`endif

  assign w_pc_inc = r_pc + ADDR_W'(1);

  mc14500b_ret_stack #(
    .DEPTH  (STACK_DEPTH),
    .DATA_W (ADDR_W),
    .SP_W   (SP_W)
  ) u_ret_stack (
    .i_clk     (clk_in),
    .i_rst     (rst),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_din     (w_pc_inc),
    .o_top_c   (w_stack_top),
    .o_sp      (sp),
    .o_full_c  (w_stack_full),
    .o_empty_c (w_stack_empty)
  );

  // Next-state, PC redirect and stack control
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_ir_nxt          = r_ir;
    w_instr_valid_nxt = r_instr_valid;
    w_running_nxt     = r_running;
    w_stack_err_nxt   = r_stack_err;
    w_push            = 1'b0;
    w_pop             = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt   = ST_FETCH;
          w_running_nxt = 1'b1;
        end
      end

      ST_FETCH: begin
        w_state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        w_ir_nxt          = prog_data;
        w_instr_valid_nxt = 1'b1;
        w_state_nxt       = ST_EXEC;
      end

      ST_EXEC: begin
        if (step) begin
          w_instr_valid_nxt = 1'b0;
          w_state_nxt       = ST_FETCH;
          if (jmp) begin
            if (w_stack_full) begin
              w_stack_err_nxt = 1'b1;
            end else begin
              w_push   = 1'b1;
              w_pc_nxt = r_ir[ADDR_W-1:0];
            end
          end else if (rtn) begin
            if (w_stack_empty) begin
              w_stack_err_nxt = 1'b1;
            end else begin
              w_pop    = 1'b1;
              w_pc_nxt = w_stack_top;
            end
          end
`ifdef MC14500B_HALT_ON_NOPF_EN
          else if (flgf) begin
            w_pc_nxt      = w_pc_inc;
            w_state_nxt   = ST_HALT;
            w_running_nxt = 1'b0;
          end
`endif
          else begin
            w_pc_nxt = w_pc_inc;
          end

          // Stack fault freezes the sequencer until reset
          if (w_stack_err_nxt && !r_stack_err) begin
            w_state_nxt   = ST_ERR;
            w_running_nxt = 1'b0;
            w_ir_nxt      = '0;
          end
        end
      end

`ifdef MC14500B_HALT_ON_NOPF_EN
      ST_HALT: begin
        if (start) begin
          w_state_nxt   = ST_FETCH;
          w_running_nxt = 1'b1;
        end
      end
`endif

      ST_ERR: begin
        w_ir_nxt          = '0;
        w_instr_valid_nxt = 1'b0;
        w_running_nxt     = 1'b0;
      end

      default: begin
        w_state_nxt       = ST_IDLE;
        w_instr_valid_nxt = 1'b0;
        w_running_nxt     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_ir          <= '0;
      r_instr_valid <= 1'b0;
      r_running     <= 1'b0;
      r_stack_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_ir          <= w_ir_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_running     <= w_running_nxt;
      r_stack_err   <= w_stack_err_nxt;
    end
  end

  assign prog_addr   = r_pc;
  assign I           = r_ir[IR_W-1:ADDR_W];
  assign io_addr     = r_ir[ADDR_W-1:0];
  assign instr_valid = r_instr_valid;
  assign running     = r_running;
  assign stack_err   = r_stack_err;

endmodule

// File: tb/tb_mc14500b_fetch_seq.sv
// Randomized bench for mc14500b_fetch_seq against an instruction-level model
// (PC as an integer, return stack as a queue, synchronous ROM as an array).
module tb_mc14500b_fetch_seq;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SP_W   = 3;
  localparam int unsigned PSIZE  = 1 << ADDR_W;
`ifdef MC14500B_HALT_ON_NOPF_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic              clk_in = 1'b0;
  logic              rst    = 1'b0;
  logic              start  = 1'b0;
  logic              step   = 1'b0;
  logic              jmp    = 1'b0;
  logic              rtn    = 1'b0;
  logic              flgf   = 1'b0;
  logic [ADDR_W-1:0] prog_addr;
  logic [11:0]       rom_q = '0;
  logic [3:0]        w_i;
  logic [ADDR_W-1:0] io_addr;
  logic              instr_valid;
  logic              running;
  logic              stack_err;
  logic [SP_W-1:0]   sp;

  logic [11:0] rom [PSIZE];

  int m_pc;
  int m_stack [$];
  bit m_err;
  bit m_halt;
  int n_checks = 0;
  int n_errors = 0;

  mc14500b_fetch_seq #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (DEPTH),
    .SP_W        (SP_W)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .start       (start),
    .step        (step),
    .jmp         (jmp),
    .rtn         (rtn),
    .flgf        (flgf),
    .prog_addr   (prog_addr),
    .prog_data   (rom_q),
    .I           (w_i),
    .io_addr     (io_addr),
    .instr_valid (instr_valid),
    .running     (running),
    .stack_err   (stack_err),
    .sp          (sp)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) rom_q <= rom[prog_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (model pc 0x%0h, t=%0t)", tag, act, exp, m_pc, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_prog_addr"}, 32'(prog_addr), 32'h0);
    chk({tag, "_I"}, 32'(w_i), 32'h0);
    chk({tag, "_io_addr"}, 32'(io_addr), 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_running"}, 32'(running), 32'h0);
    chk({tag, "_stack_err"}, 32'(stack_err), 32'h0);
    chk({tag, "_sp"}, 32'(sp), 32'h0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; start = 1'b0; step = 1'b0; jmp = 1'b0; rtn = 1'b0; flgf = 1'b0;
    tick();
    check_reset_vals(tag);
    rst = 1'b0;
    m_pc = 0;
    m_stack.delete();
    m_err = 1'b0;
    m_halt = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_running", 32'(running), 32'h1);
  endtask

  // One instruction: wait for fetch, check it, hold a few cycles, step with given flags
  task automatic do_instr(input bit j, input bit r, input bit f);
    int n;
    int extra;
    logic [11:0] w;
    n = 0;
    while (!instr_valid && n < 12) begin
      tick();
      n++;
    end
    chk("valid_wait", 32'(instr_valid), 32'h1);
    w = rom[m_pc];
    chk("prog_addr", 32'(prog_addr), 32'(m_pc));
    chk("I", 32'(w_i), 32'(w[11:8]));
    chk("io_addr", 32'(io_addr), 32'(w[7:0]));
    chk("sp", 32'(sp), 32'(m_stack.size()));
    chk("exec_running", 32'(running), 32'h1);

    extra = int'($urandom_range(0, 2));
    for (int k = 0; k < extra; k++) begin
      start = 1'($urandom_range(0, 1));
      jmp   = 1'($urandom_range(0, 1));
      rtn   = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    chk("exec_hold_I", 32'(w_i), 32'(w[11:8]));
    chk("exec_hold_valid", 32'(instr_valid), 32'h1);

    step = 1'b1; jmp = j; rtn = r; flgf = f;
    tick();
    step = 1'b0; jmp = 1'b0; rtn = 1'b0; flgf = 1'b0;

    if (j) begin
      if (m_stack.size() == DEPTH) m_err = 1'b1;
      else begin
        m_stack.push_back((m_pc + 1) % PSIZE);
        m_pc = int'(w[7:0]);
      end
    end else if (r) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else m_pc = m_stack.pop_back();
    end else begin
      m_pc = (m_pc + 1) % PSIZE;
      if (f && HALT_EN) m_halt = 1'b1;
    end

    if (m_err) begin
      chk("err_flag", 32'(stack_err), 32'h1);
      chk("err_running", 32'(running), 32'h0);
      chk("err_valid", 32'(instr_valid), 32'h0);
      chk("err_I", 32'(w_i), 32'h0);
      chk("err_sp", 32'(sp), 32'(m_stack.size()));
      chk("err_pc", 32'(prog_addr), 32'(m_pc));
    end else if (m_halt) begin
      chk("halt_running", 32'(running), 32'h0);
      chk("halt_valid", 32'(instr_valid), 32'h0);
    end else begin
      chk("step_valid_drop", 32'(instr_valid), 32'h0);
      n = 0;
      while (!instr_valid && n < 12) begin
        chk("fetch_running", 32'(running), 32'h1);
        tick();
        n++;
      end
      chk("fetch_latency", 32'(n), 32'h2);
    end
  endtask

  task automatic err_followup();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("err_start_ignored", 32'(running), 32'h0);
    chk("err_sticky", 32'(stack_err), 32'h1);
    chk("err_hold_I", 32'(w_i), 32'h0);
    chk("err_hold_pc", 32'(prog_addr), 32'(m_pc));
  endtask

  task automatic halt_followup();
    repeat (3) tick();
    chk("halt_stays", 32'(running), 32'h0);
    chk("halt_no_fetch", 32'(instr_valid), 32'h0);
    chk("halt_pc", 32'(prog_addr), 32'(m_pc));
    do_start();
    m_halt = 1'b0;
  endtask

  task automatic fill_rom_random();
    for (int i = 0; i < int'(PSIZE); i++) rom[i] = 12'($urandom);
  endtask

  initial begin
    bit rj, rr, rf;
    int n;
    fill_rom_random();
    rom[0]    = {4'h1, 8'h05};
    rom[1]    = {4'h3, 8'h06};
    rom[2]    = {4'h8, 8'h07};
    rom[3]    = {4'hC, 8'h40};
    rom[8'h40] = {4'hD, 8'h00};
    rom[4]    = {4'hC, 8'h50};
    rom[8'h50] = {4'hC, 8'h60};
    rom[8'h60] = {4'hC, 8'h70};
    rom[8'h70] = {4'hC, 8'h80};
    rom[8'h80] = {4'hC, 8'h90};
    @(negedge clk_in);

    do_reset("rst0");
    step = 1'b1; jmp = 1'b1;
    tick();
    step = 1'b0; jmp = 1'b0;
    tick();
    chk("idle_ignores_step", 32'(running), 32'h0);
    chk("idle_sp", 32'(sp), 32'h0);

    do_start();
    do_instr(1'b0, 1'b0, 1'b0);
    do_instr(1'b0, 1'b0, 1'b0);
    do_instr(1'b0, 1'b0, 1'b0);
    do_instr(1'b1, 1'b0, 1'b0);
    do_instr(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) do_instr(1'b1, 1'b0, 1'b0);
    chk("nest_overflow_err", 32'(stack_err), 32'h1);
    chk("nest_overflow_sp", 32'(sp), 32'(DEPTH));
    err_followup();

    do_reset("rst1");
    do_start();
    do_instr(1'b0, 1'b1, 1'b0);
    chk("underflow_err", 32'(stack_err), 32'h1);
    err_followup();

    do_reset("rst2");
    rom[0] = {4'hC, 8'hFF};
    do_start();
    do_instr(1'b1, 1'b0, 1'b0);
    do_instr(1'b0, 1'b0, 1'b0);
    chk("wrap_pc", 32'(prog_addr), 32'h0);
    do_instr(1'b1, 1'b1, 1'b0);
    chk("jmp_beats_rtn_sp", 32'(sp), 32'h2);
    n = 0;
    while (!instr_valid && n < 12) begin
      tick();
      n++;
    end
    chk("mid_exec_valid", 32'(instr_valid), 32'h1);
    do_reset("rst_exec");

    rom[0] = {4'hC, 8'h09};
    rom[9] = {4'hF, 8'h00};
    do_start();
    do_instr(1'b1, 1'b0, 1'b0);
    do_instr(1'b0, 1'b0, 1'b1);
    if (m_halt) halt_followup();
    do_instr(1'b0, 1'b0, 1'b0);

    do_reset("rst_rand");
    fill_rom_random();
    do_start();
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset("rst_rand_mid");
        fill_rom_random();
        do_start();
      end
      rj = ($urandom_range(0, 99) < 25);
      rr = ($urandom_range(0, 99) < 20);
      rf = ($urandom_range(0, 99) < 20);
      do_instr(rj, rr, rf);
      if (m_err) begin
        err_followup();
        do_reset("rst_after_err");
        do_start();
      end else if (m_halt) begin
        halt_followup();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
